addr_bus_arbiter: RTL and testbench

//  Shares the SDIO address controller bank registers between two requesters (0 = host CPU port, 1 = SDIO port).

---
 rtl/addr_bus_arbiter_pkg.sv | 21 ++
 rtl/addr_bus_arbiter_rr_arb2.sv | 35 +++
 rtl/addr_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_addr_bus_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_bus_arbiter_pkg.sv
// Shared widths, requester ids and FSM encoding
// for the SDIO address bus arbiter.
package addr_bus_arbiter_pkg;

    localparam int DWIDTH     = 8;
    localparam int BSWIDTH    = 3;
    localparam int ADDR_BYTES = 3;
    localparam int CNT_WIDTH  = 9;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_SDIO = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STRB,
        ST_XFER,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/addr_bus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the requester not
// served last wins a tie.
module rr_arb2
    import addr_bus_arbiter_pkg::*;
(
    input  logic       SC_PClk,
    input  logic       SC_ResetN,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       served,
    output logic [1:0] gnt
);

    logic last_q;

    // Reset to SDIO so the host wins the first tie.
    always_ff @(negedge SC_PClk or negedge SC_ResetN) begin
        if (!SC_ResetN) begin
            last_q <= REQ_SDIO;
        end else if (upd) begin
            last_q <= served;
        end
    end

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == REQ_HOST) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/addr_bus_arbiter.sv
// Arbitrates two requesters onto the address bank
// registers, loads the start address, gates the data phase.
module addr_bus_arbiter #(
    parameter int DWIDTH     = addr_bus_arbiter_pkg::DWIDTH,
    parameter int BSWIDTH    = addr_bus_arbiter_pkg::BSWIDTH,
    parameter int ADDR_BYTES = addr_bus_arbiter_pkg::ADDR_BYTES,
    parameter int CNT_WIDTH  = addr_bus_arbiter_pkg::CNT_WIDTH
) (
    input  logic                         SC_PClk,
    input  logic                         SC_ResetN,
    input  logic [1:0]                   AR_Req,
    input  logic [DWIDTH*ADDR_BYTES-1:0] AR_Addr0,
    input  logic [DWIDTH*ADDR_BYTES-1:0] AR_Addr1,
    input  logic [CNT_WIDTH-1:0]         AR_Cnt0,
    input  logic [CNT_WIDTH-1:0]         AR_Cnt1,
    input  logic                         AR_Inc0,
    input  logic                         AR_Inc1,
    input  logic                         AR_Xfer,
    output logic [1:0]                   AR_Gnt,
    output logic                         AR_Busy,
    output logic                         AR_Done,
    output logic [DWIDTH-1:0]            SC_Data_Bus,
    output logic [BSWIDTH-1:0]           SC_BSel,
    output logic                         SC_StrbN,
    output logic                         SC_Addr_Inc
);

    import addr_bus_arbiter_pkg::*;

    localparam int AW = DWIDTH * ADDR_BYTES;
    localparam logic [BSWIDTH:0] LAST_IDX = (BSWIDTH+1)'(ADDR_BYTES);

    arb_state_e           state_q, state_d;
    logic                 sel_q, sel_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 inc_q, inc_d;
    logic [BSWIDTH:0]     idx_q, idx_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [1:0]           arb_gnt;
    logic                 rr_upd;
    logic                 held;
    logic                 done_d, strbn_d, ainc_d;
    logic [DWIDTH-1:0]    bus_d;
    logic [BSWIDTH-1:0]   bsel_d;

    function automatic logic [DWIDTH-1:0] addr_byte(
        input logic [AW-1:0]    a,
        input logic [BSWIDTH:0] k
    );
        addr_byte = '0;
        for (int b = 0; b < ADDR_BYTES; b++) begin
            if (k == (BSWIDTH+1)'(b)) addr_byte = a[b*DWIDTH +: DWIDTH];
        end
    endfunction

    rr_arb2 u_rr (
        .SC_PClk   (SC_PClk),
        .SC_ResetN (SC_ResetN),
        .req       (AR_Req),
        .upd       (rr_upd),
        .served    (sel_q),
        .gnt       (arb_gnt)
    );

    assign held    = AR_Req[sel_q];
    assign AR_Gnt  = gnt_q;
    assign AR_Busy = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        inc_d   = inc_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        rr_upd  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|AR_Req) begin
                    sel_d   = arb_gnt[1];
                    addr_d  = arb_gnt[1] ? AR_Addr1 : AR_Addr0;
                    cnt_d   = arb_gnt[1] ? AR_Cnt1 : AR_Cnt0;
                    inc_d   = arb_gnt[1] ? AR_Inc1 : AR_Inc0;
                    idx_d   = '0;
                    gnt_d   = arb_gnt;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_STRB;
            ST_STRB: begin
                idx_d = idx_q + 1'b1;
                if (idx_d != LAST_IDX) state_d = ST_LOAD;
                else if (cnt_q == '0)  state_d = ST_DONE;
                else                   state_d = ST_XFER;
            end
            ST_XFER: begin
                if (AR_Xfer && cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_WIDTH'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                rr_upd  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Requester withdrew mid-transaction: drop silently.
        if (!held && state_q inside {ST_LOAD, ST_STRB, ST_XFER}) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            rr_upd  = 1'b1;
        end
    end

    // Outputs are decoded from the next state and registered.
    always_comb begin
        bus_d  = '0;
        bsel_d = '0;
        if (state_d == ST_LOAD || state_d == ST_STRB) begin
            bus_d  = addr_byte(addr_d, idx_d);
            bsel_d = idx_d[BSWIDTH-1:0];
        end
        strbn_d = (state_d != ST_STRB);
        ainc_d  = (state_d == ST_XFER) && inc_d;
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(negedge SC_PClk or negedge SC_ResetN) begin
        if (!SC_ResetN) begin
            state_q     <= ST_IDLE;
            sel_q       <= REQ_HOST;
            addr_q      <= '0;
            cnt_q       <= '0;
            inc_q       <= 1'b0;
            idx_q       <= '0;
            gnt_q       <= '0;
            AR_Done     <= 1'b0;
            SC_Data_Bus <= '0;
            SC_BSel     <= '0;
            SC_StrbN    <= 1'b1;
            SC_Addr_Inc <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            inc_q       <= inc_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            AR_Done     <= done_d;
            SC_Data_Bus <= bus_d;
            SC_BSel     <= bsel_d;
            SC_StrbN    <= strbn_d;
            SC_Addr_Inc <= ainc_d;
        end
    end

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Bench for addr_bus_arbiter: vector table, directed
// corner sequences and random traffic against a model.
module tb_addr_bus_arbiter;

    localparam int AB = 3;
    localparam logic [16:0] RST_O = 17'h00002;

    typedef struct {
        logic [1:0]  req;
        logic        xfer;
        logic [16:0] exp;
    } vec_t;

    logic        clk = 1'b1;
    logic        rst_n = 1'b1;
    logic [1:0]  req = '0;
    logic [23:0] addr0 = '0, addr1 = '0;
    logic [8:0]  cnt0 = '0, cnt1 = '0;
    logic        inc0 = 1'b0, inc1 = 1'b0, xfer = 1'b0;
    logic [1:0]  gnt;
    logic        busy, done, strbn, ainc;
    logic [7:0]  bus;
    logic [2:0]  bsel;
    logic [16:0] dut_o;

    int n_chk = 0;
    int n_pass = 0;

    int          m_ph, m_step, m_rem, m_who, m_last;
    logic        m_inc;
    logic [23:0] m_addr;

    always #5 clk = ~clk;

    addr_bus_arbiter dut (
        .SC_PClk     (clk),
        .SC_ResetN   (rst_n),
        .AR_Req      (req),
        .AR_Addr0    (addr0),
        .AR_Addr1    (addr1),
        .AR_Cnt0     (cnt0),
        .AR_Cnt1     (cnt1),
        .AR_Inc0     (inc0),
        .AR_Inc1     (inc1),
        .AR_Xfer     (xfer),
        .AR_Gnt      (gnt),
        .AR_Busy     (busy),
        .AR_Done     (done),
        .SC_Data_Bus (bus),
        .SC_BSel     (bsel),
        .SC_StrbN    (strbn),
        .SC_Addr_Inc (ainc)
    );

    assign dut_o = {gnt, busy, done, bus, bsel, strbn, ainc};

    function automatic int pick(input logic [1:0] r, input int last);
        if (r == 2'b11) return 1 - last;
        return r[1] ? 1 : 0;
    endfunction

    // Transaction-level model: a step counter walks the
    // 2*AB address-load cycles, then a remaining-byte count.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_step <= 0; m_rem <= 0;
            m_who <= 0; m_last <= 1; m_inc <= 1'b0; m_addr <= '0;
        end else begin
            case (m_ph)
                0: if (req != 2'b00) begin
                    m_who  <= pick(req, m_last);
                    m_addr <= pick(req, m_last) == 1 ? addr1 : addr0;
                    m_rem  <= pick(req, m_last) == 1 ? int'(cnt1) : int'(cnt0);
                    m_inc  <= pick(req, m_last) == 1 ? inc1 : inc0;
                    m_step <= 0;
                    m_ph   <= 1;
                end
                1: if (!req[m_who]) begin
                    m_ph <= 0; m_last <= m_who;
                end else begin
                    m_step <= m_step + 1;
                    if (m_step == 2*AB-1) m_ph <= (m_rem == 0) ? 3 : 2;
                end
                2: if (!req[m_who]) begin
                    m_ph <= 0; m_last <= m_who;
                end else if (xfer && m_rem > 0) begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) m_ph <= 3;
                end
                default: begin
                    m_ph <= 0; m_last <= m_who;
                end
            endcase
        end
    end

    function automatic logic [16:0] model_o();
        logic [1:0] g;
        logic [7:0] b;
        logic [2:0] s;
        g = (m_ph == 0) ? 2'b00 : (m_who == 1 ? 2'b10 : 2'b01);
        b = (m_ph == 1) ? 8'(m_addr >> (8 * (m_step / 2))) : 8'h00;
        s = (m_ph == 1) ? 3'(m_step / 2) : 3'd0;
        return {g, m_ph != 0, m_ph == 3, b, s,
                !(m_ph == 1 && (m_step % 2) == 1),
                (m_ph == 2) && m_inc};
    endfunction

    function automatic vec_t row(
        input logic [1:0] r, input logic x, input logic [1:0] g,
        input logic bz, input logic d, input logic [7:0] b,
        input logic [2:0] s, input logic sn, input logic ai
    );
        vec_t v;
        v.req = r;
        v.xfer = x;
        v.exp = {g, bz, d, b, s, sn, ai};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00;
        xfer = 1'b0;
        #1;
        chk("reset_outputs", dut_o, RST_O);
        @(posedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t tv[$];
        logic [1:0] g[3];
        int ng, first_done;
        logic ainc_seen;

        // Host load of 0x123456, no data phase.
        tv.push_back(row(2'b01, 0, 2'b01, 1, 0, 8'h56, 3'd0, 1, 0));
        tv.push_back(row(2'b01, 0, 2'b01, 1, 0, 8'h56, 3'd0, 0, 0));
        tv.push_back(row(2'b01, 0, 2'b01, 1, 0, 8'h34, 3'd1, 1, 0));
        tv.push_back(row(2'b01, 0, 2'b01, 1, 0, 8'h34, 3'd1, 0, 0));
        tv.push_back(row(2'b01, 0, 2'b01, 1, 0, 8'h12, 3'd2, 1, 0));
        tv.push_back(row(2'b01, 0, 2'b01, 1, 0, 8'h12, 3'd2, 0, 0));
        tv.push_back(row(2'b01, 0, 2'b01, 1, 1, 8'h00, 3'd0, 1, 0));
        tv.push_back(row(2'b00, 0, 2'b00, 0, 0, 8'h00, 3'd0, 1, 0));
        // SDIO load of 0xABCDEF then four gapped transfers.
        tv.push_back(row(2'b10, 0, 2'b10, 1, 0, 8'hEF, 3'd0, 1, 0));
        tv.push_back(row(2'b10, 0, 2'b10, 1, 0, 8'hEF, 3'd0, 0, 0));
        tv.push_back(row(2'b10, 0, 2'b10, 1, 0, 8'hCD, 3'd1, 1, 0));
        tv.push_back(row(2'b10, 0, 2'b10, 1, 0, 8'hCD, 3'd1, 0, 0));
        tv.push_back(row(2'b10, 0, 2'b10, 1, 0, 8'hAB, 3'd2, 1, 0));
        tv.push_back(row(2'b10, 1, 2'b10, 1, 0, 8'hAB, 3'd2, 0, 0));
        tv.push_back(row(2'b10, 1, 2'b10, 1, 0, 8'h00, 3'd0, 1, 1));
        tv.push_back(row(2'b10, 1, 2'b10, 1, 0, 8'h00, 3'd0, 1, 1));
        tv.push_back(row(2'b10, 0, 2'b10, 1, 0, 8'h00, 3'd0, 1, 1));
        tv.push_back(row(2'b10, 1, 2'b10, 1, 0, 8'h00, 3'd0, 1, 1));
        tv.push_back(row(2'b10, 0, 2'b10, 1, 0, 8'h00, 3'd0, 1, 1));
        tv.push_back(row(2'b10, 1, 2'b10, 1, 0, 8'h00, 3'd0, 1, 1));
        tv.push_back(row(2'b10, 0, 2'b10, 1, 0, 8'h00, 3'd0, 1, 1));
        tv.push_back(row(2'b10, 1, 2'b10, 1, 1, 8'h00, 3'd0, 1, 0));
        tv.push_back(row(2'b00, 1, 2'b00, 0, 0, 8'h00, 3'd0, 1, 0));
        tv.push_back(row(2'b00, 1, 2'b00, 0, 0, 8'h00, 3'd0, 1, 0));

        #2;
        do_reset();

        addr0 = 24'h123456; cnt0 = 9'd0; inc0 = 1'b1;
        addr1 = 24'hABCDEF; cnt1 = 9'd4; inc1 = 1'b1;
        foreach (tv[k]) begin
            req = tv[k].req;
            xfer = tv[k].xfer;
            tick();
            chk($sformatf("vec%0d", k), dut_o, tv[k].exp);
            if (k == 1) begin
                addr0 = 24'hFFFFFF;
                cnt0 = 9'd7;
            end
        end

        // No increment, count 3, AR_Xfer held from IDLE onward.
        addr0 = 24'h0A0B0C; cnt0 = 9'd3; inc0 = 1'b0;
        req = 2'b01; xfer = 1'b1;
        first_done = 0; ainc_seen = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            ainc_seen |= ainc;
            if (done && first_done == 0) first_done = t;
            if (t == 10) begin
                req = 2'b00;
                xfer = 1'b0;
            end
        end
        chk("t6_done_cycle", first_done, 10);
        chk("t6_addr_inc", ainc_seen, 0);

        // Both held after reset: grants alternate.
        do_reset();
        cnt0 = 9'd0; cnt1 = 9'd0;
        req = 2'b11;
        ng = 0; g[0] = 2'b00; g[1] = 2'b00; g[2] = 2'b00;
        for (int t = 0; t < 60 && ng < 3; t++) begin
            logic [1:0] prev;
            prev = gnt;
            tick();
            if (prev == 2'b00 && gnt != 2'b00) begin
                g[ng] = gnt;
                ng++;
            end
        end
        chk("t2_grant_count", ng, 3);
        chk("t2_grant0", g[0], 2'b01);
        chk("t2_grant1", g[1], 2'b10);
        chk("t2_grant2", g[2], 2'b01);
        req = 2'b00;
        tick();
        tick();
        chk("t2_idle", dut_o, RST_O);

        // Host drops request during strobe of byte 1.
        do_reset();
        addr0 = 24'h112233;
        req = 2'b11;
        repeat (4) tick();
        chk("t4_strb_byte1", {gnt, bus, bsel, strbn}, {2'b01, 8'h22, 3'd1, 1'b0});
        req = 2'b10;
        tick();
        chk("t4_abort", dut_o, RST_O);
        tick();
        chk("t4_next_gnt", gnt, 2'b10);
        req = 2'b00;
        tick();
        tick();

        // Reset mid data phase with two transfers left.
        do_reset();
        addr1 = 24'h445566; cnt1 = 9'd4; inc1 = 1'b1;
        req = 2'b10;
        repeat (7) tick();
        xfer = 1'b1;
        tick();
        tick();
        xfer = 1'b0;
        chk("t5_in_xfer", {busy, ainc, done}, 3'b110);
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset", dut_o, RST_O);
        @(posedge clk);
        rst_n = 1'b1;
        req = 2'b11;
        tick();
        chk("t5_gnt_after_reset", gnt, 2'b01);
        req = 2'b00;
        tick();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req[r]) begin
                    if ($urandom_range(3) == 0) req[r] = 1'b1;
                end else if ((m_ph == 3 && m_who == r) ||
                             $urandom_range(59) == 0) begin
                    req[r] = 1'b0;
                end
            end
            xfer  = 1'($urandom_range(1));
            addr0 = 24'($urandom);
            addr1 = 24'($urandom);
            cnt0  = 9'($urandom_range(5));
            cnt1  = 9'($urandom_range(5));
            inc0  = 1'($urandom_range(1));
            inc1  = 1'($urandom_range(1));
            tick();
            chk($sformatf("rnd%0d", c), dut_o, model_o());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
